// File: rtl/iterative_wordred_if.sv
// Operand/result handshake bundle for iterative_wordred.
// Source drives C/qH with in_valid; sink takes T on out_valid && out_ready.
interface iterative_wordred_if #(
    parameter int unsigned K      = 120,
    parameter int unsigned QH_LEN = 30,
    parameter int unsigned O_SIZE = 61
);
    logic              in_valid;
    logic              in_ready;
    logic [QH_LEN-1:0] qH;
    logic [K-1:0]      C;
    logic              out_valid;
    logic              out_ready;
    logic [O_SIZE-1:0] T;

    modport master (
        output in_valid, qH, C, out_ready,
        input  in_ready, out_valid, T
    );

    modport slave (
        input  in_valid, qH, C, out_ready,
        output in_ready, out_valid, T
    );
endinterface

// File: rtl/iterative_wordred.sv
// Iterative word-level Montgomery reduction, one R-bit round per cycle, L rounds.
// Define WORDRED_FINAL_SUB_EN to add a final conditional subtraction (T < q instead of T < 2q).
module iterative_wordred #(
    parameter int unsigned K     = 120,
    parameter int unsigned Q_LEN = 60,
    parameter int unsigned R     = 30,
    parameter int unsigned Y     = 0,
    parameter int unsigned L     = 2
) (
    input logic             clk,
    input logic             rst,
    iterative_wordred_if.slave bus
);
    localparam int unsigned QH_LEN = Q_LEN - R - Y;
    localparam int unsigned O_SIZE = Q_LEN + 1;
    localparam int unsigned CW     = (L > 1) ? $clog2(L) : 1;

`ifdef WORDRED_FINAL_SUB_EN
    typedef enum logic [1:0] {StIdle, StRun, StDone, StSub} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
`endif

    state_e            state;
    logic [K-1:0]      acc;
    logic [QH_LEN-1:0] qh_q;
    logic [CW-1:0]     cnt;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [R-1:0]        cl;
    logic [R-1:0]        m;
    logic                carry;
    logic [QH_LEN+R-1:0] prod;
    logic [K-1:0]        acc_next;

    // (acc + q*m) / 2^R with q = qH*2^(R+Y)+1: the low word plus m always
    // sums to 0 or 2^R, so only a carry survives the shift.
    always_comb begin
        cl       = acc[R-1:0];
        m        = ~cl + 1'b1;
        carry    = |cl;
        prod     = {{R{1'b0}}, qh_q} * {{QH_LEN{1'b0}}, m};
        acc_next = (acc >> R) + K'(carry) + (K'(prod) << Y);
    end

`ifdef WORDRED_FINAL_SUB_EN
    logic [K-1:0] q_full;
    assign q_full = K'({qh_q, {(R + Y){1'b0}}}) + K'(1'b1);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= StIdle;
            acc         <= '0;
            qh_q        <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        acc        <= bus.C;
                        qh_q       <= bus.qH;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= StRun;
                    end
                end
                StRun: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(L - 1)) begin
`ifdef WORDRED_FINAL_SUB_EN
                        state <= StSub;
`else
                        state       <= StDone;
                        out_valid_q <= 1'b1;
`endif
                    end
                end
`ifdef WORDRED_FINAL_SUB_EN
                StSub: begin
                    if (acc >= q_full) acc <= acc - q_full;
                    state       <= StDone;
                    out_valid_q <= 1'b1;
                end
`endif
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.T         = acc[O_SIZE-1:0];
endmodule

// File: tb/tb_iterative_wordred.sv
// Self-checking bench for iterative_wordred (K=32, Q_LEN=16, R=8, Y=0, L=2).
// Expected results come from the Montgomery definition T = (C + q*M) / 2^16.
module tb_iterative_wordred;
    localparam int unsigned K = 32, Q_LEN = 16, R = 8, Y = 0, L = 2;
    localparam int unsigned QH_LEN = Q_LEN - R - Y;
    localparam int unsigned O_SIZE = Q_LEN + 1;
`ifdef WORDRED_FINAL_SUB_EN
    localparam int LAT = L + 2;
    localparam logic [O_SIZE-1:0] EXP_Q = 17'h00000;
`else
    localparam int LAT = L + 1;
    localparam logic [O_SIZE-1:0] EXP_Q = 17'h0F101;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    iterative_wordred_if #(.K(K), .QH_LEN(QH_LEN), .O_SIZE(O_SIZE)) bus ();

    iterative_wordred #(.K(K), .Q_LEN(Q_LEN), .R(R), .Y(Y), .L(L)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // L rounds of exact Montgomery division by 2^R, then optional final subtraction.
    function automatic longint unsigned model(longint unsigned c, longint unsigned qh);
        longint unsigned q, t, m;
        q = (qh << (R + Y)) + 1;
        t = c;
        for (int r = 0; r < L; r++) begin
            m = ((1 << R) - (t % (1 << R))) % (1 << R);
            t = (t + q * m) / (1 << R);
        end
`ifdef WORDRED_FINAL_SUB_EN
        if (t >= q) t = t - q;
`endif
        return t;
    endfunction

    task automatic do_op(input logic [K-1:0] c, input logic [QH_LEN-1:0] qh,
                         output logic [O_SIZE-1:0] t, output int lat, output bit ok);
        int n;
        ok  = 1'b0;
        t   = '0;
        lat = 0;
        bus.C = c;
        bus.qH = qh;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 40) begin tick(); n++; end
        if (!bus.in_ready) begin bus.in_valid = 1'b0; return; end
        tick();
        // Scramble inputs after accept: only the captured copies may matter.
        bus.in_valid = 1'b0;
        bus.C = $urandom();
        bus.qH = QH_LEN'($urandom());
        lat = 1;
        while (!bus.out_valid && lat < 40) begin tick(); lat++; end
        if (!bus.out_valid) return;
        ok = 1'b1;
        t  = bus.T;
        if (bus.out_ready) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.C = '0;
        bus.qH = '0;
        repeat (3) tick();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        n_checks++;
        if (bus.T !== '0) begin
            n_fail++; $display("FAIL reset_T: got %h expected 0", bus.T);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_zero();
        logic [O_SIZE-1:0] t;
        int lat;
        bit ok;
        bus.out_ready = 1'b1;
        do_op(32'h0, 8'hF1, t, lat, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL zero_timeout: got %b expected 1", ok); end
        n_checks++;
        if (t !== '0) begin n_fail++; $display("FAIL zero_T: got %h expected 0", t); end
        n_checks++;
        if (lat != LAT) begin n_fail++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL zero_one_cycle_valid: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_one();
        logic [O_SIZE-1:0] t;
        int lat;
        bit ok;
        bus.out_ready = 1'b1;
        do_op(32'h1, 8'hF1, t, lat, ok);
        // (1 + q*255)/256 = 0xF010, then (0xF010 + q*0xF0)/256 = 0xE2E1 (= 2^-16 mod q).
        n_checks++;
        if (t !== 17'h0E2E1) begin n_fail++; $display("FAIL one_T: got %h expected 0e2e1", t); end
        n_checks++;
        if (lat != LAT) begin n_fail++; $display("FAIL one_latency: got %0d expected %0d", lat, LAT); end
    endtask

    task automatic test_q();
        logic [O_SIZE-1:0] t;
        int lat;
        bit ok;
        bus.out_ready = 1'b1;
        do_op(32'h0000F101, 8'hF1, t, lat, ok);
        n_checks++;
        if (t !== EXP_Q) begin n_fail++; $display("FAIL q_T: got %h expected %h", t, EXP_Q); end
    endtask

    task automatic test_backpressure();
        logic [O_SIZE-1:0] t;
        longint unsigned c, exp_t;
        int lat;
        bit ok;
        c = longint'($urandom()) % (64'd61697 * 64'd61697);
        exp_t = model(c, 64'hF1);
        bus.out_ready = 1'b0;
        do_op(K'(c), 8'hF1, t, lat, ok);
        n_checks++;
        if (t !== O_SIZE'(exp_t)) begin
            n_fail++; $display("FAIL bp_T: got %h expected %h", t, O_SIZE'(exp_t));
        end
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = k[0];
            bus.C = $urandom();
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.T !== t || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: got valid=%b T=%h in_ready=%b expected valid=1 T=%h in_ready=0",
                         bus.out_valid, bus.T, bus.in_ready, t);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b in_ready=%b expected valid=0 in_ready=1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [O_SIZE-1:0] t;
        int lat;
        bit ok;
        bus.out_ready = 1'b1;
        bus.C = 32'h12345678;
        bus.qH = 8'hF1;
        bus.in_valid = 1'b1;
        tick();                 // accepted
        bus.in_valid = 1'b0;
        tick();                 // round 1 done
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: got valid=%b in_ready=%b expected valid=0 in_ready=0",
                     bus.out_valid, bus.in_ready);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.T !== '0) begin
            n_fail++;
            $display("FAIL midreset_idle: got in_ready=%b valid=%b T=%h expected 1 0 0",
                     bus.in_ready, bus.out_valid, bus.T);
        end
        do_op(32'h1, 8'hF1, t, lat, ok);
        n_checks++;
        if (t !== 17'h0E2E1) begin n_fail++; $display("FAIL midreset_recover: got %h expected 0e2e1", t); end
    endtask

    task automatic test_back_to_back();
        longint unsigned qh, q, c, exp_t;
        int n;
        bit done;
        for (int i = 0; i < 100; i++) begin
            qh = $urandom_range(1, 255);
            q  = (qh << R) + 1;
            c  = longint'($urandom()) % (q * q);
            exp_t = model(c, qh);
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            bus.C = K'(c);
            bus.qH = QH_LEN'(qh);
            bus.in_valid = 1'b1;
            n = 0;
            while (!bus.in_ready && n < 40) begin bus.out_ready = 1'($urandom()); tick(); n++; end
            if (!bus.in_ready) begin
                bus.in_valid = 1'b0;
                n_checks++; n_fail++;
                $display("FAIL b2b_accept_timeout: op %0d got in_ready=0 expected 1", i);
                continue;
            end
            tick();
            bus.in_valid = 1'b0;
            bus.qH = QH_LEN'($urandom());
            n = 0;
            done = 1'b0;
            while (!done && n < 60) begin
                bus.out_ready = 1'($urandom());
                if (bus.out_valid && bus.out_ready) begin
                    done = 1'b1;
                    n_checks++;
                    if (bus.T !== O_SIZE'(exp_t)) begin
                        n_fail++;
                        $display("FAIL b2b_T: op %0d C=%h qH=%h got %h expected %h",
                                 i, c, qh, bus.T, O_SIZE'(exp_t));
                    end
                    n_checks++;
                    if (((longint'(bus.T) << 16) % q) != (c % q)) begin
                        n_fail++;
                        $display("FAIL b2b_congruence: op %0d got T*2^16 mod q=%0d expected %0d",
                                 i, (longint'(bus.T) << 16) % q, c % q);
                    end
                end
                tick();
                n++;
            end
            if (!done) begin
                n_checks++; n_fail++;
                $display("FAIL b2b_result_timeout: op %0d got no result expected one", i);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_one();
        test_q();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
